// File: rtl/tick_divider_multi.sv
// Multi-channel clock-enable generator on a single clock domain.
// Each channel divides clk by its own constant divisor and produces a
// one-cycle tick per period plus a square wave at the same frequency.
// Channels selected by PAUSE_MASK freeze (count and square wave hold, no
// tick) while pause is high.
//
// Ports:
//   clk      in   1       system clock
//   rst      in   1       synchronous, active-high reset
//   pause    in   1       freeze masked channels while high
//   restart  in   1       synchronous phase clear of all channels
//   tick     out  NUM_CH  one-cycle enable pulse per channel period
//   sq       out  NUM_CH  square wave per channel
//
// Channel i divisor is DIV_LIST[i*CNT_W +: CNT_W]; it must be >= 1.

module tick_divider_multi #(
  parameter int unsigned              NUM_CH     = 4,
  parameter int unsigned              CNT_W      = 27,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_LIST   = {27'd100000, 27'd25000000,
                                                    27'd50000000, 27'd100000000},
  parameter logic [NUM_CH-1:0]        PAUSE_MASK = NUM_CH'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              restart,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] DivV   = DIV_LIST[i*CNT_W +: CNT_W];
    localparam logic [CNT_W-1:0] Last   = DivV - CNT_W'(1);
    // Mid-period toggle point; only meaningful when DivV >= 2.
    localparam logic [CNT_W-1:0] MidV   = (DivV >> 1) - CNT_W'(1);
    localparam bit               HasMid = (DivV > CNT_W'(1));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             frozen;

    assign frozen = pause & PAUSE_MASK[i];

    always_comb begin
      cnt_d  = cnt_q;
      sq_d   = sq_q;
      tick_d = 1'b0;
      if (restart) begin
        // Restart beats pause: phase clears even on frozen channels.
        cnt_d = '0;
        sq_d  = 1'b0;
      end else if (!frozen) begin
        if (cnt_q == Last) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Never coincides with the wrap toggle since MidV < Last.
          if (HasMid && (cnt_q == MidV)) begin
            sq_d = ~sq_q;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_tick_divider_multi.sv
// Scoreboarded bench for tick_divider_multi with three channels:
// ch0 DIV=1, ch1 DIV=4, ch2 DIV=5, ch1/ch2 honour pause.
// The model counts unpaused edges since the last clear per channel and
// derives tick/sq from that count arithmetically.

module tb_tick_divider_multi;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              pause;
  logic              restart;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  tick_divider_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DIV_LIST   ({8'd5, 8'd4, 8'd1}),
    .PAUSE_MASK (3'b110)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pause   (pause),
    .restart (restart),
    .tick    (tick),
    .sq      (sq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned div_v [NUM_CH] = '{1, 4, 5};
  bit          pmask [NUM_CH] = '{0, 1, 1};
  int unsigned k     [NUM_CH];  // counting edges since last clear

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic logic sq_of(int unsigned cnt, int unsigned d);
    if (d >= 2) return ((cnt % d) >= (d / 2));
    return cnt[0];
  endfunction

  // Apply inputs for the coming posedge, predict the result, then wait.
  task automatic step(input logic r, input logic rs, input logic p);
    exp_t e;
    rst     = r;
    restart = rs;
    pause   = p;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r || rs) begin
        k[c]      = 0;
        e.tick[c] = 1'b0;
      end else if (p && pmask[c]) begin
        e.tick[c] = 1'b0;
      end else begin
        k[c]      = k[c] + 1;
        e.tick[c] = ((k[c] % div_v[c]) == 0);
      end
      e.sq[c] = sq_of(k[c], div_v[c]);
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Run freely until channel ch sits at phase ph (bounded).
  task automatic run_to_phase(input int ch, input int unsigned ph, input string tag);
    int n = 0;
    while ((k[ch] % div_v[ch]) != ph && n < 20) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    n_checks++;
    if ((k[ch] % div_v[ch]) != ph) begin
      n_fails++;
      $display("FAIL %s: phase %0d, wanted %0d", tag, k[ch] % div_v[ch], ph);
    end
  endtask

  // Monitor: every cycle the DUT presents tick/sq; compare against queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL scoreboard_empty: got tick=%b sq=%b, no expectation", tick, sq);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (tick !== e.tick) begin
          n_fails++;
          $display("FAIL tick @%0t: got %b, expected %b", $time, tick, e.tick);
        end
        n_checks++;
        if (sq !== e.sq) begin
          n_fails++;
          $display("FAIL sq @%0t: got %b, expected %b", $time, sq, e.sq);
        end
      end
    end
  end

  initial begin
    bit p_rand;
    for (int c = 0; c < NUM_CH; c++) k[c] = 0;

    // Initial reset, then free run covering several ch1/ch2 periods.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (23) step(1'b0, 1'b0, 1'b0);

    // Reset held three cycles mid-run, then free run again.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // Pause ten cycles with ch1 at count 2; ch0 keeps ticking.
    run_to_phase(1, 2, "pause_setup");
    repeat (10) step(1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Pause on the wrap count of ch2: tick deferred to first unpaused edge.
    run_to_phase(2, 4, "pause_wrap_setup");
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Restart with pause on the same edge, pause held, then released.
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    repeat (9) step(1'b0, 1'b0, 1'b0);

    // One-edge reset exactly when ch2's tick is due.
    run_to_phase(2, 4, "rst_wrap_setup");
    step(1'b1, 1'b0, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);

    // Randomized traffic with pause bursts and occasional clears.
    p_rand = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) p_rand = ~p_rand;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0), p_rand);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
